// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispense controller: FSM states,
// named item slots and the default stock counter width.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CHECK     = 2'd1,
    ST_MOTOR     = 2'd2,
    ST_WAIT_DROP = 2'd3
  } state_e;

  localparam int unsigned VAFLA_BOROVEC = 0;
  localparam int unsigned PATRON_VODKA  = 1;
  localparam int unsigned ZLATNA_ARDA   = 2;
  localparam int unsigned SLANINA       = 3;

  localparam int unsigned STOCK_W_DEFAULT = 4;

endpackage

// File: rtl/vend_stock_bank.sv
// Per-slot stock counters and jam flags with saturating restock, guarded
// decrement and a registered availability vector.
module vend_stock_bank
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned STOCK_W    = STOCK_W_DEFAULT,
  parameter int unsigned INIT_STOCK = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rs_en,
  input  logic [$clog2(NUM_ITEMS)-1:0] rs_item,
  input  logic [STOCK_W-1:0]           rs_qty,
  input  logic [$clog2(NUM_ITEMS)-1:0] op_item,
  input  logic                         dec_en,
  input  logic                         jam_en,
  output logic                         op_ok,
  output logic [NUM_ITEMS-1:0]         available
);

  localparam int unsigned IDX_W = $clog2(NUM_ITEMS);
  localparam logic [STOCK_W-1:0] STOCK_MAX  = {STOCK_W{1'b1}};
  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);
  localparam logic [NUM_ITEMS-1:0] AVAIL_INIT =
    (INIT_STOCK != 0) ? {NUM_ITEMS{1'b1}} : {NUM_ITEMS{1'b0}};

  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] jam_q;
  logic [NUM_ITEMS-1:0] jam_d;
  logic [NUM_ITEMS-1:0] available_q;
  logic [NUM_ITEMS-1:0] available_d;

  // Wider sum keeps the carry so overflow clamps to the full-slot value.
  function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                 input logic [STOCK_W-1:0] b);
    logic [STOCK_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[STOCK_W]) begin
      sat_add = STOCK_MAX;
    end else begin
      sat_add = sum[STOCK_W-1:0];
    end
  endfunction

  // Next-state per slot; an out-of-range index matches no slot.
  always_comb begin
    op_ok = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_d[i]     = stock_q[i];
      jam_d[i]       = jam_q[i];
      available_d[i] = (stock_q[i] != {STOCK_W{1'b0}}) && !jam_q[i];
      op_ok = op_ok | ((op_item == IDX_W'(i)) &&
                       (stock_q[i] != {STOCK_W{1'b0}}) && !jam_q[i]);
      if (rs_en && (rs_item == IDX_W'(i))) begin
        stock_d[i] = sat_add(stock_q[i], rs_qty);
        jam_d[i]   = 1'b0;
      end else if (dec_en && (op_item == IDX_W'(i)) && (stock_q[i] != {STOCK_W{1'b0}})) begin
        stock_d[i] = stock_q[i] - {{(STOCK_W-1){1'b0}}, 1'b1};
      end else if (jam_en && (op_item == IDX_W'(i))) begin
        jam_d[i] = 1'b1;
      end else begin
        stock_d[i] = stock_q[i];
      end
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= STOCK_INIT;
      end
      jam_q       <= {NUM_ITEMS{1'b0}};
      available_q <= AVAIL_INIT;
    end else begin
      stock_q     <= stock_d;
      jam_q       <= jam_d;
      available_q <= available_d;
    end
  end

  assign available = available_q;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: checks the slot, pulses the motor, then waits for the
// drop sensor under a timeout; restocks are accepted while idle.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS      = 4,
  parameter int unsigned STOCK_W        = STOCK_W_DEFAULT,
  parameter int unsigned INIT_STOCK     = 0,
  parameter int unsigned MOTOR_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         disp_req,
  input  logic [$clog2(NUM_ITEMS)-1:0] disp_item,
  output logic                         disp_ack,
  output logic                         disp_err,
  output logic                         busy,
  output logic [NUM_ITEMS-1:0]         motor_en,
  input  logic                         drop_sense,
  input  logic                         restock_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] restock_item,
  input  logic [STOCK_W-1:0]           restock_qty,
  output logic                         restock_ready,
  output logic [NUM_ITEMS-1:0]         available
);

  localparam int unsigned IDX_W   = $clog2(NUM_ITEMS);
  localparam int unsigned CNT_MAX = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] MOTOR_LOAD   = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic                 drop_seen_q, drop_seen_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_ITEMS-1:0] motor_en_q, motor_en_d;
  logic                 disp_ack_q, disp_ack_d;
  logic                 disp_err_q, disp_err_d;
  logic                 dec_en, jam_en, op_ok, rs_en;

  assign restock_ready = (state_q == ST_IDLE);
  assign rs_en         = restock_valid && restock_ready;

  vend_stock_bank #(
    .NUM_ITEMS  (NUM_ITEMS),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .rs_en     (rs_en),
    .rs_item   (restock_item),
    .rs_qty    (restock_qty),
    .op_item   (sel_q),
    .dec_en    (dec_en),
    .jam_en    (jam_en),
    .op_ok     (op_ok),
    .available (available)
  );

  // Next-state, timer and pulse decisions; pulses land one edge later.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    drop_seen_d = drop_seen_q;
    cnt_d       = cnt_q;
    disp_ack_d  = 1'b0;
    disp_err_d  = 1'b0;
    dec_en      = 1'b0;
    jam_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (disp_req) begin
          sel_d       = disp_item;
          drop_seen_d = 1'b0;
          state_d     = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (!op_ok) begin
          disp_err_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d   = MOTOR_LOAD;
          state_d = ST_MOTOR;
        end
      end
      ST_MOTOR: begin
        drop_seen_d = drop_seen_q | drop_sense;
        if (cnt_q == {CNT_W{1'b0}}) begin
          cnt_d   = TIMEOUT_LOAD;
          state_d = ST_WAIT_DROP;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WAIT_DROP: begin
        if (drop_seen_q || drop_sense) begin
          dec_en     = 1'b1;
          disp_ack_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          jam_en     = 1'b1;
          disp_err_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d == ST_MOTOR) begin
      motor_en_d = {{(NUM_ITEMS-1){1'b0}}, 1'b1} << sel_d;
    end else begin
      motor_en_d = {NUM_ITEMS{1'b0}};
    end
  end

  // Controller registers; reset drops the motor without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= {IDX_W{1'b0}};
      drop_seen_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      motor_en_q  <= {NUM_ITEMS{1'b0}};
      disp_ack_q  <= 1'b0;
      disp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      drop_seen_q <= drop_seen_d;
      cnt_q       <= cnt_d;
      motor_en_q  <= motor_en_d;
      disp_ack_q  <= disp_ack_d;
      disp_err_q  <= disp_err_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign motor_en = motor_en_q;
  assign disp_ack = disp_ack_q;
  assign disp_err = disp_err_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl with default parameters; expected
// values are hand-computed from the cycle timing of the controller.
module tb_vend_dispense_ctrl;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       disp_ack;
  logic       disp_err;
  logic       busy;
  logic [3:0] motor_en;
  logic       drop_sense;
  logic       restock_valid;
  logic [1:0] restock_item;
  logic [3:0] restock_qty;
  logic       restock_ready;
  logic [3:0] available;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int n;
  int m;

  always #5 clk = ~clk;

  vend_dispense_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .disp_req      (disp_req),
    .disp_item     (disp_item),
    .disp_ack      (disp_ack),
    .disp_err      (disp_err),
    .busy          (busy),
    .motor_en      (motor_en),
    .drop_sense    (drop_sense),
    .restock_valid (restock_valid),
    .restock_item  (restock_item),
    .restock_qty   (restock_qty),
    .restock_ready (restock_ready),
    .available     (available)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b0;
    disp_req      = 1'b0;
    disp_item     = 2'd0;
    drop_sense    = 1'b0;
    restock_valid = 1'b0;
    restock_item  = 2'd0;
    restock_qty   = 4'd0;
    repeat (2) step();

    check_eq("rst_available", 32'(available), 32'h0);
    check_eq("rst_motor_en", 32'(motor_en), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_ack", 32'(disp_ack), 32'h0);
    check_eq("rst_err", 32'(disp_err), 32'h0);
    check_eq("rst_ready", 32'(restock_ready), 32'h1);
    rst = 1'b1;
    step();

    // restock item 2 with 3 units
    restock_valid = 1'b1; restock_item = 2'(ZLATNA_ARDA); restock_qty = 4'd3;
    step();
    restock_valid = 1'b0;
    check_eq("restock_stock2", 32'(dut.u_bank.stock_q[2]), 32'd3);
    check_eq("avail_lag", 32'(available), 32'h0);
    step();
    check_eq("avail_after_restock", 32'(available), 32'h4);

    // vend item 2, drop seen on the 2nd WAIT_DROP cycle
    disp_req = 1'b1; disp_item = 2'(ZLATNA_ARDA);
    step();
    disp_req = 1'b0;
    check_eq("check_busy", 32'(busy), 32'h1);
    check_eq("check_motor_off", 32'(motor_en), 32'h0);
    check_eq("check_not_ready", 32'(restock_ready), 32'h0);
    step();
    n = 0;
    while (motor_en == 4'b0100 && n < 20) begin
      n++;
      step();
    end
    check_eq("motor_len", 32'(n), 32'd8);
    check_eq("motor_off_wait", 32'(motor_en), 32'h0);
    step();
    drop_sense = 1'b1;
    check_eq("ack_not_early", 32'(disp_ack), 32'h0);
    step();
    drop_sense = 1'b0;
    check_eq("vend_ack", 32'(disp_ack), 32'h1);
    check_eq("vend_no_err", 32'(disp_err), 32'h0);
    check_eq("vend_stock2", 32'(dut.u_bank.stock_q[2]), 32'd2);
    check_eq("vend_idle", 32'(busy), 32'h0);
    step();
    check_eq("ack_one_pulse", 32'(disp_ack), 32'h0);

    // empty slot
    disp_req = 1'b1; disp_item = 2'(PATRON_VODKA);
    step();
    disp_req = 1'b0;
    check_eq("empty_err_early", 32'(disp_err), 32'h0);
    step();
    check_eq("empty_err", 32'(disp_err), 32'h1);
    check_eq("empty_motor", 32'(motor_en), 32'h0);
    check_eq("empty_no_ack", 32'(disp_ack), 32'h0);
    step();
    check_eq("empty_err_pulse", 32'(disp_err), 32'h0);

    // timeout: no drop on item 2
    disp_req = 1'b1; disp_item = 2'(ZLATNA_ARDA);
    step();
    disp_req = 1'b0;
    n = 0;
    while (!disp_err && n < 100) begin
      step();
      n++;
    end
    check_eq("timeout_edges", 32'(n), 32'd41);
    check_eq("timeout_jam", 32'(dut.u_bank.jam_q[2]), 32'h1);
    check_eq("timeout_stock", 32'(dut.u_bank.stock_q[2]), 32'd2);
    check_eq("timeout_avail_lag", 32'(available), 32'h4);
    step();
    check_eq("jam_avail", 32'(available), 32'h0);
    restock_valid = 1'b1; restock_item = 2'(ZLATNA_ARDA); restock_qty = 4'd0;
    step();
    restock_valid = 1'b0;
    check_eq("jam_cleared", 32'(dut.u_bank.jam_q[2]), 32'h0);
    step();
    check_eq("unjam_avail", 32'(available), 32'h4);

    // saturating restock
    restock_valid = 1'b1; restock_item = 2'(VAFLA_BOROVEC); restock_qty = 4'd10;
    step();
    step();
    restock_valid = 1'b0;
    check_eq("sat_stock0", 32'(dut.u_bank.stock_q[0]), 32'd15);

    // same-edge restock and request of empty item 3
    restock_valid = 1'b1; restock_item = 2'(SLANINA); restock_qty = 4'd5;
    disp_req = 1'b1; disp_item = 2'(SLANINA);
    step();
    restock_valid = 1'b0; disp_req = 1'b0;
    check_eq("same_edge_stock3", 32'(dut.u_bank.stock_q[3]), 32'd5);
    check_eq("same_edge_busy", 32'(busy), 32'h1);
    step();
    check_eq("same_edge_motor", 32'(motor_en), 32'h8);
    drop_sense = 1'b1;
    step();
    drop_sense = 1'b0;
    n = 1;
    while (!disp_ack && n < 100) begin
      step();
      n++;
    end
    check_eq("fast_ack_edges", 32'(n), 32'd9);
    check_eq("same_edge_stock3_dec", 32'(dut.u_bank.stock_q[3]), 32'd4);

    // requests while busy are dropped
    disp_req = 1'b1; disp_item = 2'(VAFLA_BOROVEC);
    step();
    disp_req = 1'b0;
    step();
    step();
    disp_req = 1'b1; disp_item = 2'(SLANINA);
    step();
    step();
    disp_req = 1'b0;
    check_eq("busy_ignore_motor", 32'(motor_en), 32'h1);
    drop_sense = 1'b1;
    step();
    drop_sense = 1'b0;
    n = 0;
    while (!disp_ack && n < 100) begin
      step();
      n++;
    end
    check_eq("busy_ignore_ack", 32'(disp_ack), 32'h1);
    m = 0;
    repeat (12) begin
      step();
      if (motor_en != 4'b0000) m++;
    end
    check_eq("no_second_pulse", 32'(m), 32'd0);
    check_eq("busy_ignore_stock3", 32'(dut.u_bank.stock_q[3]), 32'd4);
    check_eq("busy_ignore_stock0", 32'(dut.u_bank.stock_q[0]), 32'd14);

    // reset in the middle of MOTOR
    disp_req = 1'b1; disp_item = 2'(VAFLA_BOROVEC);
    step();
    disp_req = 1'b0;
    step();
    step();
    check_eq("pre_rst_motor", 32'(motor_en), 32'h1);
    rst = 1'b0;
    #1;
    check_eq("rst_async_motor", 32'(motor_en), 32'h0);
    check_eq("rst_async_busy", 32'(busy), 32'h0);
    check_eq("rst_async_ack", 32'(disp_ack), 32'h0);
    check_eq("rst_async_err", 32'(disp_err), 32'h0);
    check_eq("rst_stock0", 32'(dut.u_bank.stock_q[0]), 32'd0);
    check_eq("rst_avail", 32'(available), 32'h0);
    step();
    rst = 1'b1;
    step();
    check_eq("post_rst_motor", 32'(motor_en), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
